// File: rtl/rggen_register_access_arbiter.sv
// Round-robin arbiter sharing one register-block command port between
// REQUESTERS hosts. One command in flight at a time; a command that never
// completes is retired with an error after TIMEOUT cycles (0 disables this).
module rggen_register_access_arbiter #(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [REQUESTERS-1:0]                 i_request_valid,
  output logic [REQUESTERS-1:0]                 o_request_ready,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0]   i_request_address,
  input  logic [REQUESTERS-1:0]                 i_request_write,
  input  logic [REQUESTERS*DATA_WIDTH-1:0]      i_request_write_data,
  input  logic [REQUESTERS*DATA_WIDTH-1:0]      i_request_write_mask,
  output logic [REQUESTERS-1:0]                 o_response_valid,
  output logic                                  o_response_error,
  output logic [DATA_WIDTH-1:0]                 o_response_read_data,
  output logic                                  o_command_valid,
  output logic [ADDRESS_WIDTH-1:0]              o_command_address,
  output logic                                  o_command_write,
  output logic [DATA_WIDTH-1:0]                 o_command_write_data,
  output logic [DATA_WIDTH-1:0]                 o_command_write_mask,
  input  logic                                  i_command_done,
  input  logic                                  i_command_error,
  input  logic [DATA_WIDTH-1:0]                 i_read_data
);

  localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(REQUESTERS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic             TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMAND,
    ST_RESPONSE
  } state_t;

  state_t state;
  state_t state_next;

  logic [PTR_W-1:0]         ptr;
  logic [PTR_W-1:0]         grant_idx;
  logic                     grant_found;
  logic [PTR_W-1:0]         hi_idx;
  logic [PTR_W-1:0]         lo_idx;
  logic                     hi_found;
  logic                     lo_found;
  logic                     accept;
  logic                     done;
  logic                     timeout;
  logic [CNT_W-1:0]         cnt;

  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic                     sel_write;
  logic [DATA_WIDTH-1:0]    sel_write_data;
  logic [DATA_WIDTH-1:0]    sel_write_mask;

  logic [ADDRESS_WIDTH-1:0] cmd_address;
  logic                     cmd_write;
  logic [DATA_WIDTH-1:0]    cmd_write_data;
  logic [DATA_WIDTH-1:0]    cmd_write_mask;
  logic                     rsp_error;
  logic [DATA_WIDTH-1:0]    rsp_read_data;

  // Round robin: lowest valid index above the last grant, else lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (i_request_valid[i]) begin
        if (i > int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = PTR_W'(i);
        end
      end
    end
    grant_found = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Mux the winning host's command fields out of the packed request buses.
  always_comb begin
    sel_address    = '0;
    sel_write      = 1'b0;
    sel_write_data = '0;
    sel_write_mask = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_address    = i_request_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_write      = i_request_write[i];
        sel_write_data = i_request_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_write_mask = i_request_write_mask[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept  = (state == ST_IDLE) && grant_found;
  assign done    = (state == ST_COMMAND) && i_command_done;
  assign timeout = (state == ST_COMMAND) && !i_command_done && TIMEOUT_EN && (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; completion has priority over the timeout.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (accept)          state_next = ST_COMMAND;
      ST_COMMAND:  if (done || timeout) state_next = ST_RESPONSE;
      ST_RESPONSE:                      state_next = ST_IDLE;
      default:                          state_next = ST_IDLE;
    endcase
  end

  // Grant pointer remembers the last host served so the next search starts after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PTR_INIT;
    end else if (accept) begin
      ptr <= grant_idx;
    end
  end

  // Cycles spent in COMMAND; cleared in every other state so each command starts at 0.
  always_ff @(posedge clk) begin
    if (rst || (state != ST_COMMAND)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Command stage: hold the accepted host's fields for the whole COMMAND phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_address    <= '0;
      cmd_write      <= 1'b0;
      cmd_write_data <= '0;
      cmd_write_mask <= '0;
    end else if (accept) begin
      cmd_address    <= sel_address;
      cmd_write      <= sel_write;
      cmd_write_data <= sel_write_data;
      cmd_write_mask <= sel_write_mask;
    end
  end

  // Response stage: capture completion status; writes and timeouts return no data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_error     <= 1'b0;
      rsp_read_data <= '0;
    end else if (done) begin
      rsp_error     <= i_command_error;
      rsp_read_data <= cmd_write ? '0 : i_read_data;
    end else if (timeout) begin
      rsp_error     <= 1'b1;
      rsp_read_data <= '0;
    end
  end

  // One-hot ready in IDLE and one-hot response in RESPONSE, both steered by the grant.
  always_comb begin
    o_request_ready  = '0;
    o_response_valid = '0;
    if (accept) begin
      o_request_ready[grant_idx] = 1'b1;
    end
    if (state == ST_RESPONSE) begin
      o_response_valid[ptr] = 1'b1;
    end
  end

  assign o_command_valid      = (state == ST_COMMAND);
  assign o_command_address    = cmd_address;
  assign o_command_write      = cmd_write;
  assign o_command_write_data = cmd_write_data;
  assign o_command_write_mask = cmd_write_mask;
  assign o_response_error     = rsp_error;
  assign o_response_read_data = rsp_read_data;

endmodule
